// File: rtl/sent_tx_scheduler.sv
// Round-robin arbiter/sequencer sharing one SENT transmitter among NUM_REQ sources; grant, enable and field latch one cycle after request.
// Requests are only sampled in IDLE; anything arriving during BUSY/GAP simply stays pending on req_i.
module sent_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_tx,
    input  logic                  reset_n_tx,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [2*NUM_REQ-1:0]  fmt_i,
    input  logic [8*NUM_REQ-1:0]  id_i,
    input  logic [16*NUM_REQ-1:0] data_i,
    input  logic [NUM_REQ-1:0]    config_i,
    input  logic [NUM_REQ-1:0]    pause_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic                  enable_o,
    output logic [1:0]            channel_format_o,
    output logic [7:0]            id_o,
    output logic [15:0]           data_bit_field_o,
    output logic                  config_bit_o,
    output logic                  optional_pause_o,
    input  logic                  idle_i,
    output logic                  busy_o,
    output logic [2:0]            active_idx_o,
    output logic                  timeout_o,
    output logic                  err_o
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [2:0]         PTR_INIT = 3'(NUM_REQ - 1);
    localparam logic               HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A zero-length gap skips the GAP state entirely.
    localparam state_t POST_TX = HAS_GAP ? ST_GAP : ST_IDLE;

    state_t             state;
    logic [2:0]         rr_ptr;
    logic               idle_q;
    logic               first_busy;
    logic [WD_W-1:0]    wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               win_vld;
    logic [2:0]         win_idx;
    int                 arb_sum;
    logic [1:0]         win_fmt;
    logic [7:0]         win_id;
    logic [15:0]        win_data;
    logic               win_cfg;
    logic               win_pause;
    logic               tx_complete;

    // Search starts just after the last winner and wraps, so the previous
    // winner is always considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        arb_sum = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_sum = int'(rr_ptr) + i;
            if (arb_sum >= NUM_REQ) begin
                arb_sum = arb_sum - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_vld && (arb_sum == j) && req_i[j]) begin
                    win_vld = 1'b1;
                    win_idx = 3'(j);
                end
            end
        end
    end

    always_comb begin
        win_fmt   = '0;
        win_id    = '0;
        win_data  = '0;
        win_cfg   = 1'b0;
        win_pause = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_idx == 3'(j)) begin
                win_fmt   = fmt_i[2*j +: 2];
                win_id    = id_i[8*j +: 8];
                win_data  = data_i[16*j +: 16];
                win_cfg   = config_i[j];
                win_pause = pause_i[j];
            end
        end
    end

    // The transmitter drops idle one edge after enable, so a rising edge seen
    // in the first BUSY cycle cannot belong to the frame just started.
    assign tx_complete = !first_busy && idle_i && !idle_q;

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state            <= ST_IDLE;
            rr_ptr           <= PTR_INIT;
            idle_q           <= 1'b0;
            first_busy       <= 1'b0;
            wd_cnt           <= '0;
            gap_cnt          <= '0;
            gnt_o            <= '0;
            done_o           <= '0;
            enable_o         <= 1'b0;
            channel_format_o <= '0;
            id_o             <= '0;
            data_bit_field_o <= '0;
            config_bit_o     <= 1'b0;
            optional_pause_o <= 1'b0;
            busy_o           <= 1'b0;
            active_idx_o     <= '0;
            timeout_o        <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            idle_q    <= idle_i;
            gnt_o     <= '0;
            done_o    <= '0;
            enable_o  <= 1'b0;
            timeout_o <= 1'b0;
            err_o     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        gnt_o            <= ONE_HOT0 << win_idx;
                        rr_ptr           <= win_idx;
                        active_idx_o     <= win_idx;
                        channel_format_o <= win_fmt;
                        id_o             <= win_id;
                        data_bit_field_o <= win_data;
                        config_bit_o     <= win_cfg;
                        optional_pause_o <= win_pause;
                        if (win_fmt == 2'b11) begin
                            // Invalid format: complete immediately with an error,
                            // never touching the transmitter.
                            err_o   <= 1'b1;
                            done_o  <= ONE_HOT0 << win_idx;
                            state   <= POST_TX;
                            busy_o  <= HAS_GAP;
                            gap_cnt <= '0;
                        end else begin
                            enable_o   <= 1'b1;
                            state      <= ST_BUSY;
                            busy_o     <= 1'b1;
                            wd_cnt     <= '0;
                            first_busy <= 1'b1;
                        end
                    end
                end

                ST_BUSY: begin
                    first_busy <= 1'b0;
                    if (tx_complete) begin
                        done_o  <= ONE_HOT0 << active_idx_o;
                        wd_cnt  <= '0;
                        state   <= POST_TX;
                        busy_o  <= HAS_GAP;
                        gap_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_o <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= POST_TX;
                        busy_o    <= HAS_GAP;
                        gap_cnt   <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sent_tx_scheduler.sv
// Bench for sent_tx_scheduler: time-stamped behavioural model checked every cycle plus directed literal checks.
module tb_sent_tx_scheduler;

    localparam int NR  = 4;
    localparam int GAP = 16;
    localparam int TMO = 100;

    logic          clk_tx = 1'b0;
    logic          reset_n_tx = 1'b0;
    logic [3:0]    req_i = '0;
    logic [7:0]    fmt_i = '0;
    logic [31:0]   id_i = '0;
    logic [63:0]   data_i = '0;
    logic [3:0]    config_i = '0;
    logic [3:0]    pause_i = '0;
    logic          idle_i = 1'b1;
    logic [3:0]    gnt_o, done_o;
    logic          enable_o, config_bit_o, optional_pause_o, busy_o, timeout_o, err_o;
    logic [1:0]    channel_format_o;
    logic [7:0]    id_o;
    logic [15:0]   data_bit_field_o;
    logic [2:0]    active_idx_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0, done_cnt = 0, to_cnt = 0;

    sent_tx_scheduler #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .req_i(req_i), .fmt_i(fmt_i),
        .id_i(id_i), .data_i(data_i), .config_i(config_i), .pause_i(pause_i),
        .gnt_o(gnt_o), .done_o(done_o), .enable_o(enable_o),
        .channel_format_o(channel_format_o), .id_o(id_o), .data_bit_field_o(data_bit_field_o),
        .config_bit_o(config_bit_o), .optional_pause_o(optional_pause_o), .idle_i(idle_i),
        .busy_o(busy_o), .active_idx_o(active_idx_o), .timeout_o(timeout_o), .err_o(err_o)
    );

    always #5 clk_tx = ~clk_tx;
    always @(posedge clk_tx) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: absolute cycle stamps ----------------
    int         mcyc = 0, m_tx_start = -1, m_gap_end = -1, m_ptr = NR - 1, m_k;
    logic       m_idle_prev = 1'b0, m_found;
    logic [3:0] e_gnt = '0, e_done = '0;
    logic       e_en = 0, e_to = 0, e_err = 0, e_busy = 0, e_cfg = 0, e_pause = 0;
    logic [2:0] e_idx = '0;
    logic [1:0] e_fmt = '0;
    logic [7:0] e_id = '0;
    logic [15:0] e_data = '0;

    always @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            m_tx_start = -1; m_gap_end = -1; m_ptr = NR - 1; m_idle_prev = 1'b0;
            e_gnt = '0; e_done = '0; e_en = 0; e_to = 0; e_err = 0; e_busy = 0;
            e_idx = '0; e_fmt = '0; e_id = '0; e_data = '0; e_cfg = 0; e_pause = 0;
        end else begin
            mcyc++;
            e_gnt = '0; e_done = '0; e_en = 0; e_to = 0; e_err = 0;
            if (m_tx_start >= 0) begin
                if ((mcyc - m_tx_start > 1) && idle_i && !m_idle_prev) begin
                    e_done = 4'b0001 << e_idx;
                    m_tx_start = -1;
                    m_gap_end = mcyc + GAP;
                end else if (mcyc - m_tx_start == TMO) begin
                    e_to = 1;
                    m_tx_start = -1;
                    m_gap_end = mcyc + GAP;
                end
            end else if (mcyc > m_gap_end) begin
                m_found = 0;
                for (int off = 1; off <= NR; off++) begin
                    m_k = (m_ptr + off) % NR;
                    if (!m_found && req_i[m_k]) begin
                        m_found = 1;
                        m_ptr = m_k;
                        e_gnt = 4'b0001 << m_k;
                        e_idx = 3'(m_k);
                        e_fmt = fmt_i[2*m_k +: 2];
                        e_id = id_i[8*m_k +: 8];
                        e_data = data_i[16*m_k +: 16];
                        e_cfg = config_i[m_k];
                        e_pause = pause_i[m_k];
                        if (e_fmt == 2'b11) begin
                            e_err = 1;
                            e_done = e_gnt;
                            m_gap_end = mcyc + GAP;
                        end else begin
                            e_en = 1;
                            m_tx_start = mcyc;
                        end
                    end
                end
            end
            e_busy = (m_tx_start >= 0) || (mcyc < m_gap_end);
            m_idle_prev = idle_i;
        end
    end

    always @(negedge clk_tx) begin
        if (cyc > 0) begin
            chk("gnt_o", 64'(gnt_o), 64'(e_gnt));
            chk("done_o", 64'(done_o), 64'(e_done));
            chk("enable_o", 64'(enable_o), 64'(e_en));
            chk("timeout_o", 64'(timeout_o), 64'(e_to));
            chk("err_o", 64'(err_o), 64'(e_err));
            chk("busy_o", 64'(busy_o), 64'(e_busy));
            chk("active_idx_o", 64'(active_idx_o), 64'(e_idx));
            chk("fields", {30'd0, channel_format_o, id_o, data_bit_field_o, config_bit_o, optional_pause_o},
                {30'd0, e_fmt, e_id, e_data, e_cfg, e_pause});
            if (enable_o) en_cnt++;
            if (|done_o) done_cnt++;
            if (timeout_o) to_cnt++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_tx);
            #1;
        end
    endtask

    function automatic logic sig_hit(input int which);
        case (which)
            0: return enable_o;
            1: return |done_o;
            2: return timeout_o;
            3: return |gnt_o;
            4: return !busy_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            if (sig_hit(which)) at = cyc;
            else step(1);
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_event_%0d: got no event within %0d cycles, required one", which, limit);
        end
    endtask

    task automatic run_tx(input int len, output int e, output int d, output logic [3:0] g);
        wait_sig(0, 100, e);
        g = gnt_o;
        step(1);
        idle_i = 1'b0;
        step(len - 2);
        idle_i = 1'b1;
        wait_sig(1, 10, d);
    endtask

    function automatic logic [63:0] all_outs();
        return {21'd0, gnt_o, done_o, enable_o, timeout_o, err_o, busy_o, active_idx_o,
                channel_format_o, id_o, data_bit_field_o, config_bit_o, optional_pause_o};
    endfunction

    int e, d, b, g_cyc, t, c0;
    logic [3:0] g;
    int e_a[5], d_a[5];
    logic [3:0] g_a[5];
    logic [3:0] rr_exp[5];

    initial begin
        fmt_i    = {2'b10, 2'b01, 2'b00, 2'b10};
        id_i     = {8'h43, 8'h32, 8'h21, 8'h00};
        data_i   = {16'hE3F3, 16'hC2D2, 16'hA1B1, 16'h0001};
        config_i = 4'b0100;
        pause_i  = 4'b1000;
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step(3);
        chk("reset_outputs", all_outs(), 64'd0);
        reset_n_tx = 1'b1;

        // single request on requester 0
        req_i = 4'b0001;
        run_tx(50, e, d, g);
        req_i = 4'b0000;
        chk("t1_gnt", 64'(g), 64'h1);
        chk("t1_fields", {30'd0, channel_format_o, id_o, data_bit_field_o, config_bit_o, optional_pause_o},
            {30'd0, 2'b10, 8'h00, 16'h0001, 1'b0, 1'b0});
        chk("t1_latency", 64'(d - e), 64'd50);
        chk("t1_done", 64'(done_o), 64'h1);
        wait_sig(4, 40, b);
        chk("t1_gap", 64'(b - d), 64'd16);

        // round robin from a fresh pointer
        reset_n_tx = 1'b0;
        step(2);
        reset_n_tx = 1'b1;
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_tx(20 + 5 * i, e, d, g);
            e_a[i] = e; d_a[i] = d; g_a[i] = g;
        end
        req_i = 4'b0000;
        for (int i = 0; i < 5; i++) chk("rr_order", 64'(g_a[i]), 64'(rr_exp[i]));
        for (int i = 0; i < 4; i++) chk("rr_spacing", 64'(e_a[i+1] - e_a[i]), 64'(20 + 5 * i + 17));
        wait_sig(4, 40, b);

        // invalid format on requester 2
        fmt_i[5:4] = 2'b11;
        req_i = 4'b0100;
        wait_sig(3, 20, g_cyc);
        chk("inv_pulses", 64'({gnt_o, err_o, done_o, enable_o}), 64'({4'b0100, 1'b1, 4'b0100, 1'b0}));
        req_i = 4'b0000;
        wait_sig(4, 40, b);
        chk("inv_gap", 64'(b - g_cyc), 64'd16);
        fmt_i[5:4] = 2'b01;

        // watchdog timeout
        req_i = 4'b0001;
        wait_sig(0, 20, e);
        req_i = 4'b0000;
        c0 = done_cnt;
        step(1);
        idle_i = 1'b0;
        wait_sig(2, 150, t);
        chk("to_latency", 64'(t - e), 64'd100);
        idle_i = 1'b1;
        wait_sig(4, 40, b);
        chk("to_gap", 64'(b - t), 64'd16);
        chk("to_no_done", 64'(done_cnt), 64'(c0));

        // idle rise in the first BUSY cycle is ignored
        idle_i = 1'b0;
        step(2);
        req_i = 4'b0010;
        wait_sig(0, 20, e);
        idle_i = 1'b1;
        step(1);
        idle_i = 1'b0;
        step(3);
        idle_i = 1'b1;
        wait_sig(1, 10, d);
        chk("first_busy_ignored", 64'(d - e), 64'd5);
        req_i = 4'b0000;
        wait_sig(4, 40, b);

        // completion coincident with watchdog expiry
        req_i = 4'b0100;
        wait_sig(0, 20, e);
        req_i = 4'b0000;
        step(1);
        idle_i = 1'b0;
        step(98);
        idle_i = 1'b1;
        c0 = to_cnt;
        wait_sig(1, 10, d);
        chk("coincident_done", 64'(d - e), 64'd100);
        wait_sig(4, 40, b);
        chk("coincident_no_timeout", 64'(to_cnt), 64'(c0));

        // reset in the middle of a transmission
        req_i = 4'b1111;
        wait_sig(0, 20, e);
        chk("pre_reset_gnt", 64'(gnt_o), 64'h8);
        step(1);
        idle_i = 1'b0;
        step(4);
        reset_n_tx = 1'b0;
        step(1);
        chk("reset_mid_outputs", all_outs(), 64'd0);
        step(2);
        idle_i = 1'b1;
        reset_n_tx = 1'b1;
        wait_sig(3, 10, g_cyc);
        chk("reset_regrant", 64'(gnt_o), 64'h1);
        req_i = 4'b0000;
        step(1);
        idle_i = 1'b0;
        step(8);
        idle_i = 1'b1;
        wait_sig(1, 10, d);
        wait_sig(4, 40, b);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, required completion before 500000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/sent_tx_scheduler.md
Name: sent_tx_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one sent_tx_control transmitter among NUM_REQ requesters (fast-channel sources, serial/enhanced message sources).
- Latches the winning requester's frame configuration, pulses the transmitter's enable and waits for its idle rising edge.
- Enforces an inter-transmission gap and a watchdog timeout, then reports completion to the requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, clk_tx cycles of enforced gap after each completion or timeout (0 allowed).
- TIMEOUT_CYCLES, 1000000, maximum clk_tx cycles in BUSY before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_tx  in  1  transmitter clock.
- reset_n_tx  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester request level; held until gnt_o.
- fmt_i  in  2*NUM_REQ  per-requester channel format (00 serial, 01 enhanced, 10 fast, 11 invalid).
- id_i  in  8*NUM_REQ  per-requester message ID.
- data_i  in  16*NUM_REQ  per-requester data_bit_field.
- config_i  in  NUM_REQ  per-requester enhanced config bit.
- pause_i  in  NUM_REQ  per-requester optional-pause select.
- gnt_o  out  NUM_REQ  one-hot, one-cycle accept pulse.
- done_o  out  NUM_REQ  one-hot, one-cycle completion pulse.
- enable_o  out  1  one-cycle start pulse to the transmitter.
- channel_format_o  out  2  latched format to the transmitter.
- id_o  out  8  latched ID.
- data_bit_field_o  out  16  latched data.
- config_bit_o  out  1  latched config bit.
- optional_pause_o  out  1  latched pause select.
- idle_i  in  1  transmitter idle flag.
- busy_o  out  1  high in BUSY and GAP.
- active_idx_o  out  3  index of the last granted requester.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- err_o  out  1  one-cycle pulse on grant of an invalid format.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority; idle_q = 0; counters 0.
- All outputs are registered.
- Arbitration: round-robin search starts at pointer+1 and wraps. The winner is the first index with req_i set. The pointer updates to the winner on each grant.
- IDLE, any req_i high at edge N, winner k:
  - At edge N+1: gnt_o[k]=1 for exactly one cycle; latch fmt/id/data/config/pause of k onto the *_o fields; active_idx_o=k; pointer=k.
  - fmt valid: enable_o=1 for exactly one cycle; state BUSY; watchdog cleared.
  - fmt==11: no enable_o; err_o=1 for one cycle; done_o[k]=1 in the same cycle; state GAP.
- Latched fields hold stable until the next grant.
- BUSY:
  - idle_q registers idle_i every cycle; completion = idle_i & ~idle_q.
  - Completion is ignored in the first cycle of BUSY, because the transmitter clears idle one edge after enable.
  - On completion: done_o[k]=1 for one cycle; state GAP; watchdog cleared.
  - Else the watchdog increments. When it reaches TIMEOUT_CYCLES-1: timeout_o=1 for one cycle; done_o not asserted; state GAP.
  - Completion and timeout in the same cycle: completion wins, no timeout_o.
- GAP:
  - Gap counter counts GAP_CYCLES cycles, then state IDLE.
  - With GAP_CYCLES=0, GAP lasts 0 cycles: the next state is IDLE directly.
  - New requests are sampled only in IDLE. Minimum enable-to-enable spacing = transmission + GAP_CYCLES + 1.
- Request handling:
  - Requests arriving in BUSY/GAP stay pending.
  - A request dropped before its grant is withdrawn with no side effects.
  - req_i[k] held through its own gnt_o is not re-granted in the same cycle. It is eligible again only after GAP, behind the other pending requesters in round-robin order.
- Reset asserted mid-transmission: immediate return to reset values; no done_o or timeout_o is emitted.
- busy_o = (state != IDLE).
- gnt_o, done_o, enable_o, timeout_o and err_o never assert for more than one consecutive cycle.

Test Plan:
- Single request: req_i=0001, fmt=10, data=16'h0001, id=8'h00. Expect gnt_o=0001 and enable_o one cycle; fields latched. Drive idle_i 0→1 after 50 cycles → done_o=0001 one cycle later, busy_o low after GAP_CYCLES=16 cycles.
- Round robin: req_i=1111 held, each transmission completed via idle_i. Expect grant order 0,1,2,3,0 and enable pulses spaced ≥ transmission+17 cycles.
- Invalid format: req_i=0100, fmt_i[5:4]=11. Expect gnt_o=0100, err_o=1 and done_o=0100 in the same cycle, no enable_o, then GAP.
- Timeout: TIMEOUT_CYCLES=100, idle_i held 0 after enable. Expect timeout_o exactly 100 cycles after enable, no done_o, return to IDLE after the gap.
- Edge cases: idle_i rising in the first BUSY cycle is ignored. idle_i rising in the same cycle the watchdog hits TIMEOUT_CYCLES-1 produces done_o with no timeout_o.
- Reset mid-BUSY: reset_n_tx low for 3 cycles. Expect all outputs 0, and the next grant goes to requester 0 while req_i=1111.
